// File: rtl/aes_block_loader_if.sv
// Word-serial handshake between the key/plaintext source and the AES block loader.
interface aes_block_loader_if;
  logic [31:0] word_in;
  logic        word_valid;
  logic        word_is_key;
  logic        word_ready;

  modport master (
    output word_in,
    output word_valid,
    output word_is_key,
    input  word_ready
  );

  modport slave (
    input  word_in,
    input  word_valid,
    input  word_is_key,
    output word_ready
  );
endinterface

// File: rtl/aes_block_loader.sv
// Assembles 32-bit key/plaintext words into AES-128 blocks and issues the
// one-cycle launch pulse that enables the initial AddRoundKey stage.
module aes_block_loader (
  input  logic                 clk,
  input  logic                 rst,
  aes_block_loader_if.slave    wif,
  input  logic                 cipher_busy_i,
  output logic [127:0]         data_block_o,
  output logic [127:0]         key_block_o,
  output logic                 key_loaded_o,
  output logic                 launch_o,
  output logic                 seq_error_o
);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_KEY    = 3'd1;
  localparam logic [2:0] S_DATA   = 3'd2;
  localparam logic [2:0] S_PEND   = 3'd3;
  localparam logic [2:0] S_LAUNCH = 3'd4;

  logic [2:0]   state_q,      state_d;
  logic [1:0]   key_cnt_q,    key_cnt_d;
  logic [1:0]   data_cnt_q,   data_cnt_d;
  logic [127:0] key_q,        key_d;
  logic [127:0] data_q,       data_d;
  logic         key_loaded_q, key_loaded_d;
  logic         seq_err_q,    seq_err_d;
  logic         ready;
  logic         accept;

  // Big-endian slice placement: word 0 lands in [127:96].
  function automatic logic [127:0] put_word(input logic [127:0] blk,
                                            input logic [1:0]   idx,
                                            input logic [31:0]  w);
    logic [127:0] r;
    r = blk;
    case (idx)
      2'd0:    r[127:96] = w;
      2'd1:    r[95:64]  = w;
      2'd2:    r[63:32]  = w;
      default: r[31:0]   = w;
    endcase
    return r;
  endfunction

  assign ready = !rst && ((state_q == S_IDLE) || (state_q == S_KEY) || (state_q == S_DATA));
  assign accept = wif.word_valid && ready;
  assign wif.word_ready = ready;

  always_comb begin
    state_d      = state_q;
    key_cnt_d    = key_cnt_q;
    data_cnt_d   = data_cnt_q;
    key_d        = key_q;
    data_d       = data_q;
    key_loaded_d = key_loaded_q;
    seq_err_d    = seq_err_q;
    case (state_q)
      S_IDLE: begin
        if (accept) begin
          if (wif.word_is_key) begin
            key_d        = put_word(key_q, 2'd0, wif.word_in);
            key_cnt_d    = 2'd1;
            key_loaded_d = 1'b0;
            state_d      = S_KEY;
          end else if (key_loaded_q) begin
            data_d     = put_word(data_q, 2'd0, wif.word_in);
            data_cnt_d = 2'd1;
            state_d    = S_DATA;
          end else begin
            seq_err_d = 1'b1;
          end
        end
      end
      S_KEY: begin
        if (accept) begin
          if (wif.word_is_key) begin
            key_d = put_word(key_q, key_cnt_q, wif.word_in);
            if (key_cnt_q == 2'd3) begin
              key_loaded_d = 1'b1;
              key_cnt_d    = 2'd0;
              state_d      = S_IDLE;
            end else begin
              key_cnt_d = key_cnt_q + 2'd1;
            end
          end else begin
            seq_err_d = 1'b1;
            key_cnt_d = 2'd0;
            state_d   = S_IDLE;
          end
        end
      end
      S_DATA: begin
        if (accept) begin
          if (!wif.word_is_key) begin
            data_d = put_word(data_q, data_cnt_q, wif.word_in);
            if (data_cnt_q == 2'd3) begin
              data_cnt_d = 2'd0;
              state_d    = S_PEND;
            end else begin
              data_cnt_d = data_cnt_q + 2'd1;
            end
          end else begin
            seq_err_d  = 1'b1;
            data_cnt_d = 2'd0;
            state_d    = S_IDLE;
          end
        end
      end
      S_PEND: begin
        if (!cipher_busy_i) state_d = S_LAUNCH;
      end
      S_LAUNCH: state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= S_IDLE;
      key_cnt_q    <= '0;
      data_cnt_q   <= '0;
      key_q        <= '0;
      data_q       <= '0;
      key_loaded_q <= 1'b0;
      seq_err_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      key_cnt_q    <= key_cnt_d;
      data_cnt_q   <= data_cnt_d;
      key_q        <= key_d;
      data_q       <= data_d;
      key_loaded_q <= key_loaded_d;
      seq_err_q    <= seq_err_d;
    end
  end

  assign data_block_o = data_q;
  assign key_block_o  = key_q;
  assign key_loaded_o = key_loaded_q;
  assign launch_o     = (state_q == S_LAUNCH);
  assign seq_error_o  = seq_err_q;

endmodule
